// File: rtl/line_bank_ctrl.sv
// line_bank_ctrl: NB round-robin line banks filled row by row from an
// input FIFO, with per-bank status, release handshake and read ports.
module line_bank_ctrl #(
  parameter int XB      = 10,
  parameter int YB      = 10,
  parameter int PB      = 8,
  parameter int NB      = 4,
  parameter int MINFILL = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic [XB-1:0]          cfg_width,
  input  logic [YB-1:0]          cfg_height,
  input  logic [PB-1:0]          inf_data,
  input  logic                   inf_valid,
  output logic                   inf_rd,
  input  logic [NB-1:0]          bank_rel,
  input  logic [NB*XB-1:0]       rd_addr,
  output logic [NB*PB-1:0]       rd_data,
  output logic [NB-1:0]          bank_full,
  output logic [NB-1:0]          bank_minfill,
  output logic [NB*YB-1:0]       bank_row,
  output logic [$clog2(NB)-1:0]  wr_bank,
  output logic [XB-1:0]          col_count,
  output logic [YB-1:0]          row_count,
  output logic                   frame_done
);

  localparam int WB    = $clog2(NB);
  localparam int DEPTH = 1 << XB;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bst_t;

  state_t        state_q, state_d;
  bst_t          bst_q  [NB];
  bst_t          bst_d  [NB];
  logic [YB-1:0] brow_q [NB];
  logic [YB-1:0] brow_d [NB];
  logic [PB-1:0] rd_q   [NB];
  logic [PB-1:0] rd_d   [NB];
  logic [XB-1:0] w_q, w_d, col_q, col_d;
  logic [YB-1:0] h_q, h_d, row_q, row_d;
  logic [WB-1:0] wb_q, wb_d;
  logic          done_q, done_d;
  logic          accept, last_col, last_row;

  logic [PB-1:0] mem [NB][DEPTH];

  // frame_start wins its cycle, so the FIFO is not popped then
  always_comb begin
    accept   = (state_q == RUN) && inf_valid &&
               (bst_q[wb_q] != B_FULL) && !frame_start;
    last_col = (col_q == w_q - XB'(1));
    last_row = (row_q == h_q - YB'(1));
  end

  assign inf_rd = accept;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    wb_d    = wb_q;
    done_d  = done_q;
    bst_d   = bst_q;
    brow_d  = brow_q;
    for (int i = 0; i < NB; i++) begin
      if (bank_rel[i] && bst_q[i] == B_FULL) bst_d[i] = B_FREE;
    end
    if (accept) begin
      if (bst_q[wb_q] == B_FREE) begin
        bst_d[wb_q]  = B_FILL;
        brow_d[wb_q] = row_q;
      end
      if (last_col) begin
        col_d       = '0;
        row_d       = row_q + YB'(1);
        bst_d[wb_q] = B_FULL;
        wb_d        = (wb_q == WB'(NB-1)) ? '0 : wb_q + WB'(1);
        if (last_row) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        col_d = col_q + XB'(1);
      end
    end
    if (frame_start) begin
      state_d = RUN;
      w_d     = cfg_width;
      h_d     = cfg_height;
      col_d   = '0;
      row_d   = '0;
      wb_d    = '0;
      done_d  = 1'b0;
      for (int i = 0; i < NB; i++) bst_d[i] = B_FREE;
    end
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      rd_d[i] = mem[i][rd_addr[i*XB +: XB]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wb_q    <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        bst_q[i]  <= B_FREE;
        brow_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wb_q    <= wb_d;
      done_q  <= done_d;
      for (int i = 0; i < NB; i++) begin
        bst_q[i]  <= bst_d[i];
        brow_q[i] <= brow_d[i];
        rd_q[i]   <= rd_d[i];
      end
    end
  end

  // storage has no reset; contents survive frames and resets
  always_ff @(posedge clk) begin
    if (accept) mem[wb_q][col_q] <= inf_data;
  end

  always_comb begin
    bank_full    = '0;
    bank_minfill = '0;
    bank_row     = '0;
    rd_data      = '0;
    for (int i = 0; i < NB; i++) begin
      bank_full[i]          = (bst_q[i] == B_FULL);
      bank_minfill[i]       = (bst_q[i] == B_FULL) ||
                              ((bst_q[i] == B_FILL) &&
                               (col_q >= XB'(MINFILL)));
      bank_row[i*YB +: YB]  = brow_q[i];
      rd_data[i*PB +: PB]   = rd_q[i];
    end
  end

  assign wr_bank    = wb_q;
  assign col_count  = col_q;
  assign row_count  = row_q;
  assign frame_done = done_q;

endmodule
